// File: rtl/locked_prio_intc.sv
// Key-locked priority interrupt controller: latches masked requests into a pending vector and
// grants them lowest-index first. The granted channel is scrambled unless the loaded key matches.
module locked_prio_intc #(
  parameter int unsigned     NCH    = 9,
  parameter int unsigned     NBUS   = 3,
  parameter int unsigned     KEYW   = 2,
  parameter logic [KEYW-1:0] KEY_OK = 2'b01
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   key_load,
  input  logic                                   key_bit,
  input  logic                                   sample,
  input  logic [NBUS*NCH-1:0]                    req,
  input  logic [NCH-1:0]                         chan_en,
  output logic                                   irq_valid,
  output logic [((NBUS > 1) ? $clog2(NBUS) : 1)-1:0] irq_bus,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   irq_chan,
  input  logic                                   irq_ack,
  output logic                                   key_ready,
  output logic [NBUS*NCH-1:0]                    pend
);

  localparam int unsigned NREQ = NBUS * NCH;
  localparam int unsigned BW   = (NBUS > 1) ? $clog2(NBUS) : 1;
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned KCW  = $clog2(KEYW + 1);

  typedef enum logic [1:0] {StIdle, StKeyLoad, StArb, StWaitAck} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [KEYW-1:0] key_q, key_d;
  logic [KCW-1:0]  key_cnt_q, key_cnt_d;
  logic            key_ready_q, key_ready_d;
  logic            irq_valid_q, irq_valid_d;
  logic [BW-1:0]   irq_bus_q, irq_bus_d;
  logic [CW-1:0]   irq_chan_q, irq_chan_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;

  logic [NREQ-1:0] sample_set;
  logic [NREQ-1:0] pend_kept;
  logic            ack_take;
  int              sel_b, sel_c, lock_c;

  // Lowest set index wins: scan high to low so the last hit is the winner.
  always_comb begin
    sel_b = 0;
    sel_c = 0;
    for (int b = int'(NBUS) - 1; b >= 0; b--) begin
      for (int c = int'(NCH) - 1; c >= 0; c--) begin
        if (pend_q[b * int'(NCH) + c]) begin
          sel_b = b;
          sel_c = c;
        end
      end
    end
    lock_c = sel_c;
    if (key_q != KEY_OK) begin
      lock_c = sel_c ^ 1;
      if (lock_c >= int'(NCH)) lock_c = lock_c - int'(NCH);
    end
  end

  always_comb begin
    sample_set = '0;
    if (sample && (state_q != StKeyLoad)) sample_set = req & {NBUS{chan_en}};
    ack_take = (state_q == StWaitAck) && irq_ack && irq_valid_q && !key_load;
    pend_kept = pend_q;
    // Clear before OR so a re-asserted request on the ack edge survives.
    if (ack_take) pend_kept[gnt_idx_q] = 1'b0;
    pend_d = pend_kept | sample_set;
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_cnt_d   = key_cnt_q;
    key_ready_d = key_ready_q;
    irq_valid_d = irq_valid_q;
    irq_bus_d   = irq_bus_q;
    irq_chan_d  = irq_chan_q;
    gnt_idx_d   = gnt_idx_q;

    if (key_load) begin
      state_d     = StKeyLoad;
      key_d       = (key_q << 1) | KEYW'(key_bit);
      if (key_cnt_q != KCW'(KEYW)) key_cnt_d = key_cnt_q + KCW'(1);
      key_ready_d = (key_cnt_d == KCW'(KEYW));
      // A presented grant is withdrawn; its pending bit is left untouched.
      irq_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StKeyLoad: state_d = StIdle;
        StIdle: begin
          if ((pend_q != '0) && key_ready_q) state_d = StArb;
        end
        StArb: begin
          if (pend_q != '0) begin
            irq_bus_d   = BW'(sel_b);
            irq_chan_d  = CW'(lock_c);
            gnt_idx_d   = IW'(sel_b * int'(NCH) + lock_c);
            irq_valid_d = 1'b1;
            state_d     = StWaitAck;
          end else begin
            state_d = StIdle;
          end
        end
        StWaitAck: begin
          if (ack_take) begin
            irq_valid_d = 1'b0;
            state_d     = (pend_d != '0) ? StArb : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      key_q       <= '0;
      key_cnt_q   <= '0;
      key_ready_q <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_bus_q   <= '0;
      irq_chan_q  <= '0;
      gnt_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      key_q       <= key_d;
      key_cnt_q   <= key_cnt_d;
      key_ready_q <= key_ready_d;
      irq_valid_q <= irq_valid_d;
      irq_bus_q   <= irq_bus_d;
      irq_chan_q  <= irq_chan_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_bus   = irq_bus_q;
  assign irq_chan  = irq_chan_q;
  assign key_ready = key_ready_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_locked_prio_intc.sv
// Directed bench for locked_prio_intc with default parameters (9 channels x 3 buses, key 01).
module tb_locked_prio_intc;

  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int NREQ = NCH * NBUS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            key_load = 1'b0;
  logic            key_bit = 1'b0;
  logic            sample = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NCH-1:0]  chan_en = '1;
  logic            irq_valid;
  logic [1:0]      irq_bus;
  logic [3:0]      irq_chan;
  logic            irq_ack = 1'b0;
  logic            key_ready;
  logic [NREQ-1:0] pend;

  int n_checks = 0;
  int n_errors = 0;

  locked_prio_intc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_bit   (key_bit),
    .sample    (sample),
    .req       (req),
    .chan_en   (chan_en),
    .irq_valid (irq_valid),
    .irq_bus   (irq_bus),
    .irq_chan  (irq_chan),
    .irq_ack   (irq_ack),
    .key_ready (key_ready),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_load = 1'b0; sample = 1'b0; req = '0; irq_ack = 1'b0; chan_en = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_key(input logic [1:0] k);
    key_load = 1'b1;
    key_bit  = k[1];
    tick();
    key_bit  = k[0];
    tick();
    key_load = 1'b0;
    tick();
  endtask

  task automatic sample_req(input logic [NREQ-1:0] r);
    sample = 1'b1;
    req    = r;
    tick();
    sample = 1'b0;
    req    = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] b, input logic [3:0] c);
    int n = 0;
    while (!irq_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, irq_valid, 1);
    check({tag, "_bus"}, irq_bus, b);
    check({tag, "_chan"}, irq_chan, c);
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    #2;
    check("rst_valid", irq_valid, 0);
    check("rst_pend", pend, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_bus", irq_bus, 0);
    check("rst_chan", irq_chan, 0);
    do_reset();

    // Single request, exact latency, hold and ack
    key_load = 1'b1; key_bit = 1'b0;
    tick();
    check("key_half_ready", key_ready, 0);
    key_bit = 1'b1;
    tick();
    check("key_full_ready", key_ready, 1);
    key_load = 1'b0;
    tick();
    sample_req(27'd1 << 4);
    check("s1_pend", pend, 27'd1 << 4);
    check("s1_lat0", irq_valid, 0);
    tick();
    check("s1_lat1", irq_valid, 0);
    tick();
    check("s1_lat2", irq_valid, 1);
    check("s1_bus", irq_bus, 0);
    check("s1_chan", irq_chan, 4);
    tick();
    check("s1_hold_valid", irq_valid, 1);
    check("s1_hold_chan", irq_chan, 4);
    ack();
    check("s1_ack_valid", irq_valid, 0);
    check("s1_ack_pend", pend, 0);
    repeat (3) tick();
    check("s1_idle_valid", irq_valid, 0);

    // Priority order across buses
    sample_req((27'd1 << 2) | (27'd1 << 10) | (27'd1 << 20));
    wait_grant("p0", 2'd0, 4'd2);
    ack();
    check("p0_pend", pend, (27'd1 << 10) | (27'd1 << 20));
    wait_grant("p1", 2'd1, 4'd1);
    ack();
    wait_grant("p2", 2'd2, 4'd2);
    ack();
    check("p_end_pend", pend, 0);

    // Key load pre-empts a presented grant
    sample_req(27'd1);
    wait_grant("pre", 2'd0, 4'd0);
    key_load = 1'b1; key_bit = 1'b0;
    tick();
    check("pre_withdrawn", irq_valid, 0);
    check("pre_pend_kept", pend, 1);
    key_bit = 1'b1;
    tick();
    key_load = 1'b0;
    tick();
    wait_grant("pre_regrant", 2'd0, 4'd0);

    // Sample and ack on the same edge: set wins for the same bit only
    irq_ack = 1'b1; sample = 1'b1; req = 27'd1;
    tick();
    irq_ack = 1'b0; sample = 1'b0; req = '0;
    check("setwin_pend", pend, 1);
    check("setwin_valid", irq_valid, 0);
    wait_grant("setwin_regrant", 2'd0, 4'd0);
    irq_ack = 1'b1; sample = 1'b1; req = 27'd2;
    tick();
    irq_ack = 1'b0; sample = 1'b0; req = '0;
    check("sameedge_pend", pend, 2);
    wait_grant("sameedge_next", 2'd0, 4'd1);
    ack();
    check("sameedge_end", pend, 0);

    // Disabled channel never latches
    chan_en = 9'h1F7;
    sample_req(27'd1 << 3);
    check("dis_pend", pend, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis_valid", irq_valid, 0);
    end
    chan_en = '1;

    // Async reset in WAIT_ACK
    sample_req(27'd1 << 4);
    wait_grant("rw", 2'd0, 4'd4);
    rst_n = 1'b0;
    #1;
    check("rw_valid", irq_valid, 0);
    check("rw_pend", pend, 0);
    check("rw_key_ready", key_ready, 0);
    do_reset();

    // No key: request latches but is not granted; stray ack ignored
    sample_req(27'd1);
    check("nk_pend", pend, 1);
    check("nk_key_ready", key_ready, 0);
    ack();
    check("nk_ack_ignored", pend, 1);
    repeat (3) tick();
    check("nk_valid", irq_valid, 0);
    load_key(2'b01);
    wait_grant("nk_after_key", 2'd0, 4'd0);
    do_reset();

    // Wrong key: channel bit 0 inverted, wrong bit cleared on ack
    load_key(2'b11);
    sample_req(27'd1 << 4);
    wait_grant("lk", 2'd0, 4'd5);
    ack();
    check("lk_pend", pend, 27'd1 << 4);
    do_reset();

    // Wrong key: channel 8 -> 9 wraps to 0
    load_key(2'b11);
    sample_req(27'd1 << 8);
    wait_grant("wrap", 2'd0, 4'd0);
    do_reset();

    // Wrong key: bus left intact
    load_key(2'b11);
    sample_req(27'd1 << 13);
    wait_grant("lkbus", 2'd1, 4'd5);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/locked_prio_intc.md
LOCKED_PRIO_INTC -- requirements
Module: locked_prio_intc

Interface
REQ-001 Parameter NCH, default 9: number of request channels per bus.
REQ-002 Parameter NBUS, default 3: number of priority buses; bus 0 is highest priority.
REQ-003 Parameter KEYW, default 2: width of the obfuscation key.
REQ-004 Parameter KEY_OK, default 2'b01: the correct key value.
REQ-005 Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  while high, shift key_bit into the key register each cycle.
- key_bit  in  1  serial key data, MSB first.
- sample  in  1  capture-request strobe.
- req  in  NBUS*NCH  raw requests; bit b*NCH+c is bus b, channel c.
- chan_en  in  NCH  per-channel enable, applied to all buses.
- irq_valid  out  1  a grant is presented.
- irq_bus  out  clog2(NBUS)  bus of the grant.
- irq_chan  out  clog2(NCH)  channel of the grant.
- irq_ack  in  1  consumer accepts the grant.
- key_ready  out  1  KEYW bits have been loaded since the last reset.
- pend  out  NBUS*NCH  pending register contents.

Function
REQ-007 The block SHALL implement the states IDLE, KEYLOAD, ARB and WAIT_ACK.
REQ-008 KEYLOAD: in any state, key_load=1 SHALL force KEYLOAD and shift one bit per cycle.
- A saturating count SHALL set key_ready once KEYW bits have been shifted in.
- Dropping key_load SHALL return the block to IDLE.
- A WAIT_ACK grant that is pre-empted by KEYLOAD SHALL be withdrawn: irq_valid goes 0 and its pending bit is kept.
REQ-009 Sampling: in IDLE, ARB or WAIT_ACK, sample=1 SHALL OR (req AND replicated chan_en) into pend on the next edge.
- Bits already set SHALL stay set.
REQ-010 IDLE SHALL move to ARB when pend is nonzero and key_ready=1.
- While key_ready=0 the block SHALL stay in IDLE and irq_valid SHALL be 0.
REQ-011 ARB (one cycle) SHALL pick the lowest set index of pend, so bus 0 first and within a bus channel 0 first.
- It SHALL register irq_bus and irq_chan, then enter WAIT_ACK with irq_valid=1.
- Latency: pend set -> irq_valid SHALL be 2 cycles when the block is in IDLE.
REQ-012 WAIT_ACK SHALL hold irq_valid, irq_bus and irq_chan stable until irq_ack=1.
- On the ack edge it SHALL clear the granted pend bit, drop irq_valid, and go to ARB if other bits remain, else IDLE.
REQ-013 A sample and an ack on the same edge SHALL clear the granted bit unless req re-asserts that same bit, in which case the bit SHALL remain set (set wins).
REQ-014 irq_ack while irq_valid=0 SHALL be ignored.
REQ-015 Locking: when the key register is not equal to KEY_OK, ARB SHALL register irq_chan with bit 0 inverted.
- Out-of-range channel values SHALL wrap modulo NCH.
- The pend bit cleared on ack SHALL be the corrupted index.
- irq_bus SHALL be unaffected.
REQ-016 NBUS*NCH up to 64 SHALL be supported.
- Priority selection SHALL be combinational within one cycle.
- All outputs SHALL be registered.

Reset
REQ-017 rst_n=0 SHALL, asynchronously, clear the state to IDLE and clear pend, key register, key count, key_ready, irq_valid, irq_bus and irq_chan.
REQ-018 Reset asserted mid-WAIT_ACK SHALL drop irq_valid immediately.
- No pending state SHALL survive the reset; the key must be reloaded.

Verification
REQ-019 Load key 01, then sample with req bit 4 (bus0, ch4) and chan_en all 1.
- Required: irq_valid 2 cycles later with bus=0, chan=4; ack clears pend to 0 and the block returns to IDLE.
REQ-020 Load key 01, then sample with req bits 2, 10 and 20.
- Required: grants (0,2), (1,1), (2,2) in that order, one grant per ack.
REQ-021 Load key 11, then sample with req bit 4.
- Required: irq_chan=5 and bus=0; ack clears pend bit 5 and bit 4 stays pending.
REQ-022 Sample with req bit 3 and chan_en[3]=0.
- Required: pend stays 0 and irq_valid never asserts.
REQ-023 Without a key load (key_ready=0), sample with req bit 0.
- Required: pend=1 and no irq_valid.
- After loading key 01: grant (0,0).
REQ-024 Assert rst_n=0 during WAIT_ACK.
- Required: irq_valid, pend and key_ready all 0 before the next clock edge.
